// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard event controller.
//   - event type codes delivered by the PS/2 driver
//   - scan codes of the tracked modifier keys
//   - FSM state encodings
//   - FIFO entry layout {mods[2:0], brk, e0, code[7:0]}
package kbd_pkg;

    localparam logic [2:0] TypeMake   = 3'b001;
    localparam logic [2:0] TypeMakeE0 = 3'b010;
    localparam logic [2:0] TypeBrk    = 3'b011;
    localparam logic [2:0] TypeBrkE0  = 3'b100;

    localparam logic [7:0] CodeAlt    = 8'h11;  // left without E0, right with E0
    localparam logic [7:0] CodeLShift = 8'h12;
    localparam logic [7:0] CodeCtrl   = 8'h14;  // left without E0, right with E0
    localparam logic [7:0] CodeRShift = 8'h59;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StEval = 2'd1;
    localparam logic [1:0] StPush = 2'd2;

    localparam int unsigned EntryW = 13;

    typedef struct packed {
        logic [2:0] mods;  // {alt, ctrl, shift}
        logic       brk;
        logic       e0;
        logic [7:0] code;
    } kbd_entry_t;

    function automatic logic type_valid(input logic [2:0] t);
        return (t == TypeMake) || (t == TypeMakeE0) || (t == TypeBrk) || (t == TypeBrkE0);
    endfunction

endpackage

// File: rtl/kbd_event_ctrl_if.sv
// Consumer-side stream of queued keyboard events (valid/ready handshake).
//   out_code/out_brk/out_e0/out_mods : head entry of the event FIFO
//   out_valid                        : FIFO not empty
//   out_ready                        : consumer accepts the head entry
// master = event controller, slave = consumer.
interface kbd_event_ctrl_if;

    logic [7:0] out_code;
    logic       out_brk;
    logic       out_e0;
    logic [2:0] out_mods;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_code, out_brk, out_e0, out_mods, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_code, out_brk, out_e0, out_mods, out_valid,
        output out_ready
    );

endinterface

// File: rtl/kbd_evt_fifo.sv
// Synchronous first-word-fall-through FIFO for keyboard event entries.
//   clk, rst     : clock, asynchronous active-low reset
//   push, wdata  : write request and data; accepted when not full or when popping
//   pop, rdata   : read request; rdata is the registered head entry
//   full, empty  : occupancy flags
//   count        : current occupancy (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module kbd_evt_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             wr_en, rd_en;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = mem_q[rd_ptr_q];
    assign count = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/kbd_event_ctrl.sv
// Keyboard event controller between the PS/2 driver and its consumers.
// Tracks left/right Shift/Ctrl/Alt, filters typematic repeats, queues events.
//   clk, rst          : clock, asynchronous active-low reset
//   ev_code/ev_type   : decoded scan event, qualified by the one-cycle ev_stb
//   ev_perr           : driver parity error (edge-detected)
//   out_bus           : FIFO head stream (valid/ready)
//   mods              : live {alt, ctrl, shift}
//   fifo_cnt          : FIFO occupancy
//   ovf, ovf_clr      : sticky drop/overflow flag and its clear
//   err_cnt           : saturating count of parity-error rising edges
module kbd_event_ctrl
    import kbd_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter bit          REPEAT_EN = 1'b0,
    parameter bit          PASS_MODS = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             ev_code,
    input  logic [2:0]             ev_type,
    input  logic                   ev_stb,
    input  logic                   ev_perr,
    kbd_event_ctrl_if.master       out_bus,
    output logic [2:0]             mods,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic                   ovf,
    input  logic                   ovf_clr,
    output logic [7:0]             err_cnt
);

    logic [1:0] state_q, state_d;
    logic [7:0] code_q;
    logic [2:0] type_q;
    logic [8:0] held_q, held_d;      // {e0, code} of the last non-repeat make
    logic       held_vld_q, held_vld_d;
    logic [5:0] side_q, side_d;      // {alt_r, alt_l, ctrl_r, ctrl_l, shift_r, shift_l}
    logic       perr_q;
    logic [7:0] err_cnt_q;
    logic       ovf_q;

    logic       brk, e0, is_mod, is_repeat, drop;
    logic [8:0] key;
    logic [5:0] mod_mask;
    logic       accept, perr_rise, ovf_set;
    logic       push, pop, full, empty;
    kbd_entry_t wr_entry, rd_entry;

    assign accept    = (state_q == StIdle) && ev_stb && type_valid(ev_type);
    assign perr_rise = ev_perr && !perr_q;
    assign mods      = {side_q[5] | side_q[4], side_q[3] | side_q[2], side_q[1] | side_q[0]};

    // Decode of the latched event; meaningful in EVAL and PUSH.
    always_comb begin
        brk      = (type_q == TypeBrk) || (type_q == TypeBrkE0);
        e0       = (type_q == TypeMakeE0) || (type_q == TypeBrkE0);
        key      = {e0, code_q};
        mod_mask = 6'b000000;
        if (!e0 && (code_q == CodeLShift)) begin
            mod_mask = 6'b000001;
        end else if (!e0 && (code_q == CodeRShift)) begin
            mod_mask = 6'b000010;
        end else if (code_q == CodeCtrl) begin
            mod_mask = e0 ? 6'b001000 : 6'b000100;
        end else if (code_q == CodeAlt) begin
            mod_mask = e0 ? 6'b100000 : 6'b010000;
        end
        is_mod    = |mod_mask;
        is_repeat = !brk && held_vld_q && (key == held_q);
        drop      = (is_repeat && !REPEAT_EN) || (is_mod && !PASS_MODS);
    end

    always_comb begin
        state_d    = state_q;
        side_d     = side_q;
        held_d     = held_q;
        held_vld_d = held_vld_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StEval;
                end
            end
            StEval: begin
                side_d = brk ? (side_q & ~mod_mask) : (side_q | mod_mask);
                if (!brk && !is_repeat) begin
                    held_d     = key;
                    held_vld_d = 1'b1;
                end else if (brk && (key == held_q)) begin
                    held_vld_d = 1'b0;
                end
                state_d = drop ? StIdle : StPush;
            end
            StPush: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // A parity error means the next make cannot be trusted as a repeat.
        if (perr_rise) begin
            held_vld_d = 1'b0;
        end
    end

    always_comb begin
        wr_entry.mods = mods;  // already updated on the EVAL exit edge
        wr_entry.brk  = brk;
        wr_entry.e0   = e0;
        wr_entry.code = code_q;
    end

    assign push    = (state_q == StPush);
    assign pop     = !empty && out_bus.out_ready;
    assign ovf_set = (ev_stb && (state_q != StIdle)) || (push && full && !pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            code_q     <= '0;
            type_q     <= '0;
            held_q     <= '0;
            held_vld_q <= 1'b0;
            side_q     <= '0;
            perr_q     <= 1'b0;
            err_cnt_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            held_vld_q <= held_vld_d;
            side_q     <= side_d;
            perr_q     <= ev_perr;
            if (accept) begin
                code_q <= ev_code;
                type_q <= ev_type;
            end
            if (perr_rise && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    kbd_evt_fifo #(
        .WIDTH(EntryW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata(wr_entry),
        .pop  (pop),
        .rdata(rd_entry),
        .full (full),
        .empty(empty),
        .count(fifo_cnt)
    );

    assign out_bus.out_code  = rd_entry.code;
    assign out_bus.out_brk   = rd_entry.brk;
    assign out_bus.out_e0    = rd_entry.e0;
    assign out_bus.out_mods  = rd_entry.mods;
    assign out_bus.out_valid = !empty;
    assign ovf               = ovf_q;
    assign err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Bench for kbd_event_ctrl: dut0 (REPEAT_EN=0) is compared every cycle against a
// queue-based event model; dut1 (REPEAT_EN=1) is only checked with literal values.
module tb_kbd_event_ctrl;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] ev_code = '0;
    logic [2:0] ev_type = '0;
    logic       ev_stb0 = 1'b0;
    logic       ev_stb1 = 1'b0;
    logic       ev_perr = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [2:0] mods0, mods1;
    logic [3:0] cnt0, cnt1;
    logic       ovf0, ovf1;
    logic [7:0] err0, err1;

    int n_checks = 0;
    int n_errors = 0;

    kbd_event_ctrl_if bus0 ();
    kbd_event_ctrl_if bus1 ();

    kbd_event_ctrl #(.DEPTH(DEPTH), .REPEAT_EN(1'b0), .PASS_MODS(1'b1)) dut0 (
        .clk(clk), .rst(rst), .ev_code(ev_code), .ev_type(ev_type), .ev_stb(ev_stb0),
        .ev_perr(ev_perr), .out_bus(bus0), .mods(mods0), .fifo_cnt(cnt0), .ovf(ovf0),
        .ovf_clr(ovf_clr), .err_cnt(err0)
    );

    kbd_event_ctrl #(.DEPTH(DEPTH), .REPEAT_EN(1'b1), .PASS_MODS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .ev_code(ev_code), .ev_type(ev_type), .ev_stb(ev_stb1),
        .ev_perr(ev_perr), .out_bus(bus1), .mods(mods1), .fifo_cnt(cnt1), .ovf(ovf1),
        .ovf_clr(ovf_clr), .err_cnt(err1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] ent(input logic [2:0] m, input logic b, input logic e,
                                        input logic [7:0] c);
        return {m, b, e, c};
    endfunction

    // ---------------- model of dut0 (REPEAT_EN=0, PASS_MODS=1) ----------------
    logic [12:0] mq[$];
    int          m_busy = 0;        // 0 free, 1 event awaiting evaluation, 2 awaiting write
    logic [7:0]  m_code = '0;
    logic [2:0]  m_type = '0;
    logic [12:0] m_entry = '0;
    logic [8:0]  m_held = '0;
    bit          m_held_vld = 0;
    bit          sl = 0, sr = 0, cl = 0, cr = 0, al = 0, ar = 0;
    bit          m_ovf = 0;
    int          m_err = 0;
    bit          m_perr_prev = 0;

    function automatic logic [2:0] m_mods();
        return {al | ar, cl | cr, sl | sr};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_busy = 0; m_held_vld = 0; m_held = '0;
            sl = 0; sr = 0; cl = 0; cr = 0; al = 0; ar = 0;
            m_ovf = 0; m_err = 0; m_perr_prev = 0;
        end else begin
            int          busy_before;
            bit          set_ovf, b, e, rep, is_mod;
            logic [12:0] gone;
            busy_before = m_busy;
            set_ovf = 0;
            if (mq.size() != 0 && bus0.out_ready) gone = mq.pop_front();
            if (m_busy == 1) begin
                b = (m_type == 3'b011) || (m_type == 3'b100);
                e = (m_type == 3'b010) || (m_type == 3'b100);
                is_mod = 1;
                if (!e && m_code == 8'h12) sl = !b;
                else if (!e && m_code == 8'h59) sr = !b;
                else if (m_code == 8'h14) begin if (e) cr = !b; else cl = !b; end
                else if (m_code == 8'h11) begin if (e) ar = !b; else al = !b; end
                else is_mod = 0;
                rep = !b && m_held_vld && ({e, m_code} == m_held);
                if (!b && !rep) begin m_held = {e, m_code}; m_held_vld = 1; end
                if (b && ({e, m_code} == m_held)) m_held_vld = 0;
                m_entry = ent(m_mods(), b, e, m_code);
                m_busy = rep ? 0 : 2;
            end else if (m_busy == 2) begin
                if (mq.size() >= DEPTH) set_ovf = 1;
                else mq.push_back(m_entry);
                m_busy = 0;
            end
            if (ev_perr && !m_perr_prev) begin
                if (m_err < 255) m_err++;
                m_held_vld = 0;
            end
            m_perr_prev = ev_perr;
            if (ev_stb0) begin
                if (busy_before != 0) set_ovf = 1;
                else if (ev_type >= 3'b001 && ev_type <= 3'b100) begin
                    m_code = ev_code; m_type = ev_type; m_busy = 1;
                end
            end
            if (set_ovf) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
        end
    end

    // ---------------- per-cycle compare of dut0 against the model ----------------
    always @(negedge clk) begin
        chk("valid", bus0.out_valid, mq.size() != 0);
        chk("fifo_cnt", cnt0, mq.size());
        if (mq.size() != 0)
            chk("head", {bus0.out_mods, bus0.out_brk, bus0.out_e0, bus0.out_code}, mq[0]);
        chk("mods", mods0, m_mods());
        chk("ovf", ovf0, m_ovf);
        chk("err_cnt", err0, m_err);
        if (!rst) chk("rst_head", {bus0.out_mods, bus0.out_brk, bus0.out_e0, bus0.out_code}, 0);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [2:0] t, input logic [1:0] sel);
        ev_code = c; ev_type = t; ev_stb0 = sel[0]; ev_stb1 = sel[1];
        tick();
        ev_stb0 = 1'b0; ev_stb1 = 1'b0;
        repeat (4) tick();
    endtask

    task automatic expect_pop0(input string name, input logic [12:0] exp);
        chk({name, "_valid"}, bus0.out_valid, 1);
        chk(name, {bus0.out_mods, bus0.out_brk, bus0.out_e0, bus0.out_code}, exp);
        bus0.out_ready = 1'b1;
        tick();
        bus0.out_ready = 1'b0;
    endtask

    task automatic expect_pop1(input string name, input logic [12:0] exp);
        chk({name, "_valid"}, bus1.out_valid, 1);
        chk(name, {bus1.out_mods, bus1.out_brk, bus1.out_e0, bus1.out_code}, exp);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
    endtask

    initial begin
        bus0.out_ready = 1'b0;
        bus1.out_ready = 1'b0;
        repeat (2) tick();
        chk("reset_valid", bus0.out_valid, 0);
        chk("reset_err", err0, 0);
        rst = 1'b1;
        tick();

        // make 1C, then break 1C; valid appears after the third edge
        ev_code = 8'h1C; ev_type = 3'b001; ev_stb0 = 1'b1;
        tick();
        ev_stb0 = 1'b0;
        chk("lat_edge0", bus0.out_valid, 0);
        tick();
        chk("lat_edge1", bus0.out_valid, 0);
        tick();
        chk("lat_edge2", bus0.out_valid, 1);
        repeat (2) tick();
        send(8'h1C, 3'b011, 2'b01);
        chk("t1_cnt", cnt0, 2);
        expect_pop0("t1_make", 13'h001C);
        expect_pop0("t1_brk", 13'h021C);

        // shift held around another key
        send(8'h12, 3'b001, 2'b01);
        chk("t2_shift_on", mods0, 3'b001);
        send(8'h1C, 3'b001, 2'b01);
        send(8'h12, 3'b011, 2'b01);
        send(8'h1C, 3'b011, 2'b01);
        chk("t2_mods_off", mods0, 3'b000);
        expect_pop0("t2_e0", ent(3'b001, 0, 0, 8'h12));
        expect_pop0("t2_e1", ent(3'b001, 0, 0, 8'h1C));
        expect_pop0("t2_e2", ent(3'b000, 1, 0, 8'h12));
        expect_pop0("t2_e3", ent(3'b000, 1, 0, 8'h1C));

        // typematic repeats on both instances
        repeat (3) send(8'h1C, 3'b001, 2'b11);
        send(8'h1C, 3'b011, 2'b11);
        chk("t3_cnt_norep", cnt0, 2);
        chk("t3_cnt_rep", cnt1, 4);
        expect_pop0("t3_d0_make", 13'h001C);
        expect_pop0("t3_d0_brk", 13'h021C);
        expect_pop1("t3_d1_m0", 13'h001C);
        expect_pop1("t3_d1_m1", 13'h001C);
        expect_pop1("t3_d1_m2", 13'h001C);
        expect_pop1("t3_d1_brk", 13'h021C);

        // overflow with the consumer stalled
        for (int i = 0; i < 9; i++) send(8'h20 + 8'(i), 3'b001, 2'b01);
        chk("t4_cnt_full", cnt0, 8);
        chk("t4_ovf", ovf0, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", ovf0, 0);
        for (int i = 0; i < 8; i++) expect_pop0("t4_drain", {5'b0, 8'h20 + 8'(i)});
        chk("t4_empty", bus0.out_valid, 0);

        // parity error breaks the repeat chain
        send(8'h1C, 3'b001, 2'b01);
        ev_perr = 1'b1;
        tick();
        ev_perr = 1'b0;
        tick();
        send(8'h1C, 3'b001, 2'b01);
        chk("t5_err1", err0, 1);
        chk("t5_cnt", cnt0, 2);
        expect_pop0("t5_e0", 13'h001C);
        expect_pop0("t5_e1", 13'h001C);
        for (int i = 0; i < 300; i++) begin
            ev_perr = 1'b1;
            tick();
            ev_perr = 1'b0;
            tick();
        end
        chk("t5_err_sat", err0, 255);

        // invalid type and a strobe during processing
        send(8'h1C, 3'b101, 2'b01);
        chk("t6_inv_cnt", cnt0, 0);
        chk("t6_inv_ovf", ovf0, 0);
        ev_code = 8'h2A; ev_type = 3'b001; ev_stb0 = 1'b1;
        tick();
        ev_code = 8'h2B;
        tick();
        ev_stb0 = 1'b0;
        repeat (4) tick();
        chk("t6_b2b_ovf", ovf0, 1);
        chk("t6_b2b_cnt", cnt0, 1);
        expect_pop0("t6_first", 13'h002A);

        // reset while an event is being evaluated
        send(8'h12, 3'b001, 2'b01);
        ev_code = 8'h2C; ev_type = 3'b001; ev_stb0 = 1'b1;
        tick();
        ev_stb0 = 1'b0;
        rst = 1'b0;
        #1;
        chk("t7_mods", mods0, 0);
        chk("t7_cnt", cnt0, 0);
        chk("t7_ovf", ovf0, 0);
        chk("t7_err", err0, 0);
        chk("t7_valid", bus0.out_valid, 0);
        chk("t7_code", bus0.out_code, 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (4) tick();
        chk("t7_lost", cnt0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
